// File: rtl/i2c_adc_sequencer_pkg.sv
// i2c_pkg: shared definitions for the I2C ADC sequencer.
//   - one-hot command flags understood by the byte-level i2c engine
//   - sequencer state encoding and step count
//   - step table helpers (command and transmit byte for each step)
package i2c_pkg;

  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_WRITE = 4'b0010;
  localparam logic [3:0] CMD_READ  = 4'b0100;
  localparam logic [3:0] CMD_STOP  = 4'b1000;

  localparam int NUM_STEPS = 4;

  typedef logic [1:0] step_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FINISH,
    S_ABORT
  } seq_state_t;

  // Register read: addressed write of the control byte, repeated start
  // with the read address, then a single read that the engine NACKs + STOPs.
  function automatic logic [3:0] step_cmd(input step_t s);
    case (s)
      2'd0:    step_cmd = CMD_START | CMD_WRITE;
      2'd1:    step_cmd = CMD_WRITE;
      2'd2:    step_cmd = CMD_START | CMD_WRITE;
      default: step_cmd = CMD_READ | CMD_STOP;
    endcase
  endfunction

  function automatic logic [7:0] step_wdata(input step_t s, input logic [6:0] id,
                                            input logic [7:0] ra);
    case (s)
      2'd0:    step_wdata = {id, 1'b0};
      2'd1:    step_wdata = ra;
      2'd2:    step_wdata = {id, 1'b1};
      default: step_wdata = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/i2c_adc_sequencer_tick_counter.sv
// tick_counter: free-running period counter for the periodic trigger.
//   clk, rst : clock, synchronous active-high reset
//   en       : count enable; low clears the counter
//   tick     : high for one cycle when the count reaches PERIOD-1
module tick_counter #(
  parameter int PERIOD = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en)       cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_adc_sequencer.sv
// i2c_adc_sequencer: drives the byte-level i2c engine through a 4-step
// register read of the ADC, on request or periodically.
//   start_req, periodic_en          : triggers (pulse / level)
//   cmd, cmd_vld, wr_data           : engine command interface
//   rd_data, rd_data_vld, done      : engine responses
//   adc_data, adc_data_vld          : last good sample + update strobe
//   busy, err                       : status
module i2c_adc_sequencer
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEVICE_ID     = 7'b1010_100,
  parameter logic [7:0] REG_ADDR      = 8'h00,
  parameter int         SAMPLE_PERIOD = 50_000,
  parameter int         TIMEOUT       = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_req,
  input  logic       periodic_en,
  output logic [3:0] cmd,
  output logic       cmd_vld,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_data,
  input  logic       rd_data_vld,
  input  logic       done,
  output logic [7:0] adc_data,
  output logic       adc_data_vld,
  output logic       busy,
  output logic       err
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam step_t LAST_STEP = step_t'(NUM_STEPS - 1);

  seq_state_t      state, state_nx;
  step_t           step;
  logic            pending, got_byte;
  logic [7:0]      shadow;
  logic [WD_W-1:0] wdog;
  logic            tick, trig;
  logic            cap;
  logic            got_nx;
  logic [7:0]      shadow_nx;

  tick_counter #(.PERIOD(SAMPLE_PERIOD)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (periodic_en),
    .tick (tick)
  );

  assign trig    = start_req | tick;
  assign cmd_vld = (state == S_ISSUE) || (state == S_ABORT);
  assign busy    = (state != S_IDLE);

  // A byte arriving in the same cycle as the final done still counts.
  assign cap       = rd_data_vld && (state == S_WAIT);
  assign got_nx    = got_byte | cap;
  assign shadow_nx = cap ? rd_data : shadow;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (trig || pending) state_nx = S_ISSUE;
      S_ISSUE:  state_nx = S_WAIT;
      S_WAIT: begin
        if (done)                 state_nx = (step == LAST_STEP) ? S_FINISH : S_ISSUE;
        else if (wdog == WD_LAST) state_nx = S_ABORT;
      end
      S_FINISH: state_nx = S_IDLE;
      S_ABORT:  state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      step         <= '0;
      pending      <= 1'b0;
      got_byte     <= 1'b0;
      shadow       <= '0;
      wdog         <= '0;
      cmd          <= '0;
      wr_data      <= '0;
      adc_data     <= '0;
      adc_data_vld <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nx;
      adc_data_vld <= 1'b0;
      // Triggers while busy coalesce into a single follow-up read.
      if (trig && state != S_IDLE) pending <= 1'b1;
      case (state)
        S_IDLE: if (state_nx == S_ISSUE) begin
          pending  <= 1'b0;
          err      <= 1'b0;
          got_byte <= 1'b0;
          step     <= '0;
          cmd      <= step_cmd(2'd0);
          wr_data  <= step_wdata(2'd0, DEVICE_ID, REG_ADDR);
        end
        S_ISSUE: wdog <= '0;
        S_WAIT: begin
          got_byte <= got_nx;
          shadow   <= shadow_nx;
          if (wdog != WD_LAST) wdog <= wdog + 1'b1;
          if (state_nx == S_ISSUE) begin
            step    <= step + 2'd1;
            wdog    <= '0;
            cmd     <= step_cmd(step + 2'd1);
            wr_data <= step_wdata(step + 2'd1, DEVICE_ID, REG_ADDR);
          end else if (state_nx == S_FINISH) begin
            // Result is published on FINISH entry so the strobe lines up with it.
            if (got_nx) begin
              adc_data     <= shadow_nx;
              adc_data_vld <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end else if (state_nx == S_ABORT) begin
            cmd <= CMD_STOP;
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_adc_sequencer.sv
// tb_i2c_adc_sequencer: directed bench for i2c_adc_sequencer with a simple
// engine model (done 10 cycles after each accepted command).
module tb_i2c_adc_sequencer;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_req = 1'b0, periodic_en = 1'b0;
  logic [3:0] cmd;
  logic       cmd_vld;
  logic [7:0] wr_data;
  logic [7:0] rd_data = 8'h00;
  logic       rd_data_vld = 1'b0, done = 1'b0;
  logic [7:0] adc_data;
  logic       adc_data_vld, busy, err;

  int n_cmp = 0, n_bad = 0;

  i2c_adc_sequencer #(
    .DEVICE_ID(7'b1010_100), .REG_ADDR(8'h00), .SAMPLE_PERIOD(100), .TIMEOUT(50)
  ) dut (
    .clk(clk), .rst(rst), .start_req(start_req), .periodic_en(periodic_en),
    .cmd(cmd), .cmd_vld(cmd_vld), .wr_data(wr_data),
    .rd_data(rd_data), .rd_data_vld(rd_data_vld), .done(done),
    .adc_data(adc_data), .adc_data_vld(adc_data_vld), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Engine model
  int   ecnt = 0;
  logic eread = 1'b0;
  int   rd_mode = 0;       // 0: byte 2 cycles before done, 1: with done, 2: none
  logic drop_step1 = 1'b0; // never answer the register-address write

  always @(posedge clk) begin
    done        <= 1'b0;
    rd_data_vld <= 1'b0;
    if (ecnt > 0) begin
      ecnt <= ecnt - 1;
      if (eread && rd_mode == 0 && ecnt == 3) begin
        rd_data <= 8'hA5; rd_data_vld <= 1'b1;
      end
      if (ecnt == 1) begin
        done <= 1'b1;
        if (eread && rd_mode == 1) begin
          rd_data <= 8'h3C; rd_data_vld <= 1'b1;
        end
      end
    end
    if (cmd_vld && cmd != CMD_STOP && !(drop_step1 && cmd == CMD_WRITE)) begin
      ecnt  <= 10;
      eread <= cmd[2];
    end
  end

  // Monitor, sampled on the falling edge
  int         cyc = 0;
  logic [3:0] log_cmd [16];
  logic [7:0] log_wd  [16];
  int         log_cyc [16];
  int         nlog = 0, nstrobe = 0, strobe_cyc = 0;
  int         fall_cyc = 0, rise_cyc = 0, last_gap = 0, last_period = 0;
  logic       busy_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_vld && nlog < 16) begin
      log_cmd[nlog] = cmd; log_wd[nlog] = wr_data; log_cyc[nlog] = cyc; nlog++;
    end
    if (adc_data_vld) begin nstrobe++; strobe_cyc = cyc; end
    if (busy_q && !busy) fall_cyc = cyc;
    if (!busy_q && busy) begin
      last_gap = cyc - fall_cyc;
      if (rise_cyc != 0) last_period = cyc - rise_cyc;
      rise_cyc = cyc;
    end
    busy_q = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start_req = 1'b1;
    @(negedge clk) start_req = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int k = 0;
    while (nlog < n && k < 500) begin @(negedge clk); k++; end
    chk("wait_log", 32'(nlog >= n), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int base_s, base_l;

  initial begin
    idle(3);
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_vld", 32'(cmd_vld), 0);
    chk("rst_wd", 32'(wr_data), 0);
    chk("rst_adc", 32'(adc_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    idle(2);

    // Single on-demand read
    nlog = 0;
    pulse_start();
    chk("issue_lat", 32'(cmd_vld), 1);
    chk("issue_busy", 32'(busy), 1);
    idle(80);
    chk("basic_n", 32'(nlog), 4);
    chk("c0", 32'(log_cmd[0]), 32'h3); chk("d0", 32'(log_wd[0]), 32'hA8);
    chk("c1", 32'(log_cmd[1]), 32'h2); chk("d1", 32'(log_wd[1]), 32'h00);
    chk("c2", 32'(log_cmd[2]), 32'h3); chk("d2", 32'(log_wd[2]), 32'hA9);
    chk("c3", 32'(log_cmd[3]), 32'hC);
    chk("basic_strobe", 32'(nstrobe), 1);
    chk("basic_adc", 32'(adc_data), 32'hA5);
    chk("basic_fall", 32'(fall_cyc - strobe_cyc), 1);
    chk("basic_err", 32'(err), 0);

    // Periodic trigger, 1000 enabled cycles
    base_s = nstrobe;
    @(negedge clk) periodic_en = 1'b1;
    idle(1000);
    periodic_en = 1'b0;
    idle(100);
    chk("per_strobes", 32'(nstrobe - base_s), 10);
    chk("per_spacing", 32'(last_period), 100);
    base_s = nstrobe;
    idle(300);
    chk("per_off", 32'(nstrobe - base_s), 0);

    // Triggers while busy coalesce into one follow-up
    nlog = 0; base_s = nstrobe;
    pulse_start();
    idle(5);
    pulse_start();
    idle(3);
    pulse_start();
    idle(200);
    chk("pend_cmds", 32'(nlog), 8);
    chk("pend_strobes", 32'(nstrobe - base_s), 2);
    chk("pend_gap", 32'(last_gap), 1);

    // Watchdog abort on step 1
    nlog = 0; base_s = nstrobe; drop_step1 = 1'b1;
    pulse_start();
    idle(150);
    chk("to_cmds", 32'(nlog), 3);
    chk("to_stop", 32'(log_cmd[2]), 32'h8);
    chk("to_when", 32'(log_cyc[2] - log_cyc[1]), 51);
    chk("to_err", 32'(err), 1);
    chk("to_adc", 32'(adc_data), 32'hA5);
    chk("to_strobe", 32'(nstrobe - base_s), 0);
    chk("to_busy", 32'(busy), 0);
    drop_step1 = 1'b0;
    base_s = nstrobe;
    pulse_start();
    chk("to_errclr", 32'(err), 0);
    idle(80);
    chk("to_recover", 32'(nstrobe - base_s), 1);
    chk("to_rec_adc", 32'(adc_data), 32'hA5);

    // Byte coincident with the final done
    rd_mode = 1;
    pulse_start();
    idle(80);
    chk("coinc_adc", 32'(adc_data), 32'h3C);
    chk("coinc_err", 32'(err), 0);

    // Final done without any byte
    rd_mode = 2; base_s = nstrobe;
    pulse_start();
    idle(80);
    chk("nobyte_err", 32'(err), 1);
    chk("nobyte_strobe", 32'(nstrobe - base_s), 0);
    chk("nobyte_adc", 32'(adc_data), 32'h3C);

    // Reset while waiting on step 2, with a pending trigger queued
    rd_mode = 0; nlog = 0;
    pulse_start();
    wait_log(2);
    pulse_start();
    wait_log(3);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_vld", 32'(cmd_vld), 0);
    rst = 1'b0;
    base_s = nstrobe; base_l = nlog;
    idle(80);
    chk("mrst_nopend", 32'(nlog - base_l), 0);
    chk("mrst_strobe", 32'(nstrobe - base_s), 0);
    chk("mrst_idle", 32'(busy), 0);
    chk("mrst_adc", 32'(adc_data), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
